// File: rtl/i2s_rx_core.sv
// I2S receiver: synchronises sck/ws/sd into clk, deserialises MSB-first
// left/right words and presents complete stereo pairs on valid/ready.
module i2s_rx_core #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          sck_in,
    input  logic          ws_in,
    input  logic          sd_in,
    output logic [DW-1:0] data_left,
    output logic [DW-1:0] data_right,
    output logic          valid,
    input  logic          ready,
    output logic          overflow,
    input  logic          clear_ovf
);

    localparam int IW = $clog2(DW + 1);

    typedef enum logic {SYNC, RUN} state_t;

    logic [2:0]    sync_reg [SYNC_STAGES];
    logic          sck_prev_reg;
    logic          sck_s, ws_s, sd_s, rise;

    state_t        state_reg, state_next;
    logic          ws_prev_reg, ws_prev_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [DW-1:0] partial_reg, partial_next;
    logic [DW-1:0] left_hold_reg, left_hold_next;
    logic          left_done_reg, left_done_next;
    logic [DW-1:0] data_left_reg, data_left_next;
    logic [DW-1:0] data_right_reg, data_right_next;
    logic          valid_reg, valid_next;
    logic          overflow_reg, overflow_next;
    logic [DW-1:0] word;
    logic          pub, drop;

    // All three bus lines share one chain so ws/sd stay aligned with sck.
    always_ff @(posedge clk) begin
        sync_reg[0] <= {sck_in, ws_in, sd_in};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
        end
        sck_prev_reg <= sck_s;
    end

    assign sck_s = sync_reg[SYNC_STAGES-1][2];
    assign ws_s  = sync_reg[SYNC_STAGES-1][1];
    assign sd_s  = sync_reg[SYNC_STAGES-1][0];
    assign rise  = sck_s & ~sck_prev_reg;

    always_comb begin
        state_next     = state_reg;
        ws_prev_next   = ws_prev_reg;
        idx_next       = idx_reg;
        partial_next   = partial_reg;
        left_hold_next = left_hold_reg;
        left_done_next = left_done_reg;
        pub            = 1'b0;
        word           = partial_reg;

        // Bits past DW match no position and are dropped.
        for (int i = 0; i < DW; i++) begin
            if (idx_reg == IW'(DW - 1 - i)) begin
                word[i] = sd_s;
            end
        end

        if (rise) begin
            ws_prev_next = ws_s;
        end

        if (!enable) begin
            state_next     = SYNC;
            idx_next       = '0;
            partial_next   = '0;
            left_done_next = 1'b0;
        end else if (rise) begin
            case (state_reg)
                SYNC: begin
                    if (ws_prev_reg && !ws_s) begin
                        state_next     = RUN;
                        idx_next       = '0;
                        partial_next   = '0;
                        left_done_next = 1'b0;
                    end
                end
                RUN: begin
                    if (ws_s != ws_prev_reg) begin
                        idx_next     = '0;
                        partial_next = '0;
                        if (!ws_prev_reg) begin
                            left_hold_next = word;
                            left_done_next = 1'b1;
                        end else begin
                            pub            = left_done_reg;
                            left_done_next = 1'b0;
                        end
                    end else begin
                        partial_next = word;
                        if (idx_reg != IW'(DW)) begin
                            idx_next = idx_reg + IW'(1);
                        end
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    always_comb begin
        data_left_next  = data_left_reg;
        data_right_next = data_right_reg;
        valid_next      = valid_reg & ~ready;
        drop            = pub & valid_reg & ~ready;
        if (pub && (!valid_reg || ready)) begin
            data_left_next  = left_hold_reg;
            data_right_next = word;
            valid_next      = 1'b1;
        end
        // A drop on the same edge as clear_ovf keeps the flag set.
        overflow_next = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= SYNC;
            ws_prev_reg    <= 1'b0;
            idx_reg        <= '0;
            partial_reg    <= '0;
            left_hold_reg  <= '0;
            left_done_reg  <= 1'b0;
            data_left_reg  <= '0;
            data_right_reg <= '0;
            valid_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ws_prev_reg    <= ws_prev_next;
            idx_reg        <= idx_next;
            partial_reg    <= partial_next;
            left_hold_reg  <= left_hold_next;
            left_done_reg  <= left_done_next;
            data_left_reg  <= data_left_next;
            data_right_reg <= data_right_next;
            valid_reg      <= valid_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign data_left  = data_left_reg;
    assign data_right = data_right_reg;
    assign valid      = valid_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_i2s_rx_core.sv
// Scoreboard bench for i2s_rx_core: frames are described as (L, R, length)
// and the expected published pair is derived from word arithmetic.
module tb_i2s_rx_core;

    logic       clk = 1'b0;
    logic       reset, enable, sck_in, ws_in, sd_in, ready, clear_ovf;
    logic [7:0] data_left, data_right;
    logic       valid, overflow;

    i2s_rx_core #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .sck_in(sck_in), .ws_in(ws_in), .sd_in(sd_in),
        .data_left(data_left), .data_right(data_right),
        .valid(valid), .ready(ready),
        .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] l; logic [7:0] r;} pair_t;
    pair_t sb[$];
    pair_t exp_pair;

    int  tests = 0;
    int  fails = 0;
    int  cycle_cnt = 0;
    int  rise_cycle = 0;
    int  lat;
    bit  lat_en = 0;
    bit  synced = 0;
    bit  hold_mode = 0;
    bit  model_pending = 0;
    bit  exp_ovf = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Left-justify an n-bit word into 8 bits: truncate long, zero-pad short.
    function automatic logic [7:0] fit(input logic [15:0] w, input int n);
        logic [15:0] t;
        if (n >= 8) t = w >> (n - 8);
        else        t = w << (8 - n);
        return t[7:0];
    endfunction

    task automatic send_bit(input logic w, input logic d, input bit mark);
        sck_in = 1'b0;
        ws_in  = w;
        sd_in  = d;
        tick(3);
        sck_in = 1'b1;
        if (mark) rise_cycle = cycle_cnt;
        tick(3);
    endtask

    // dkind: 0 none, 1 enable pulse low, 2 reset pulse, after bit dbit.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n,
                              input int dkind, input int dbit);
        pair_t p;
        p.l = fit(l, n);
        p.r = fit(r, n);
        if (synced && dkind == 0) begin
            if (!hold_mode) begin
                sb.push_back(p);
            end else if (!model_pending) begin
                sb.push_back(p);
                model_pending = 1;
            end else begin
                exp_ovf = 1;
            end
        end
        for (int k = 0; k < 2 * n; k++) begin
            bit right;
            int pos;
            right = (k >= n);
            pos   = right ? k - n : k;
            // One-bit delay: ws flips on the last bit of the current word.
            send_bit(right ? (pos != n - 1) : (pos == n - 1),
                     right ? r[n - 1 - pos] : l[n - 1 - pos],
                     right && pos == n - 1);
            if (dkind != 0 && k == dbit) begin
                synced = 0;
                if (dkind == 1) begin
                    enable = 1'b0;
                    tick(4);
                    enable = 1'b1;
                end else begin
                    reset = 1'b1;
                    tick(3);
                    check("midreset_valid", 32'(valid), 0);
                    check("midreset_data", {16'd0, data_left, data_right}, 0);
                    check("midreset_ovf", 32'(overflow), 0);
                    reset = 1'b0;
                end
            end
        end
        synced = 1;
    endtask

    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            $display("[TB] pair accepted L=%02h R=%02h", data_left, data_right);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pair: got L=%02h R=%02h required none", data_left, data_right);
            end else begin
                exp_pair = sb.pop_front();
                check("data_left", 32'(data_left), 32'(exp_pair.l));
                check("data_right", 32'(data_right), 32'(exp_pair.r));
                if (lat_en) begin
                    lat = cycle_cnt - rise_cycle;
                    tests++;
                    if (lat < 3 || lat > 4) begin
                        fails++;
                        $display("FAIL latency: got %0d required 3..4", lat);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; ready = 1'b1; clear_ovf = 1'b0;
        sck_in = 1'b0; ws_in = 1'b0; sd_in = 1'b0;
        tick(3);
        check("reset_valid", 32'(valid), 0);
        check("reset_ovf", 32'(overflow), 0);
        check("reset_data", {16'd0, data_left, data_right}, 0);
        reset = 1'b0;

        // Idle with ws held low: no framing, nothing published.
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'($urandom), 1'b0);
        check("idle_valid", 32'(valid), 0);
        check("idle_data", {16'd0, data_left, data_right}, 0);

        lat_en = 1;
        for (int i = 0; i < 3; i++) send_frame(16'hA5, 16'h3C, 8, 0, 0);
        send_frame(16'h2B7, 16'h155, 10, 0, 0);
        send_frame(16'h2D, 16'h13, 6, 0, 0);
        for (int i = 0; i < 12; i++) begin
            int n;
            n = 6 + int'($urandom_range(0, 4));
            send_frame(16'($urandom_range(0, (1 << n) - 1)),
                       16'($urandom_range(0, (1 << n) - 1)), n, 0, 0);
        end
        tick(8);

        // Back-pressure: first pair held, later pairs dropped.
        lat_en = 0; hold_mode = 1; ready = 1'b0;
        send_frame(16'h12, 16'h34, 8, 0, 0);
        tick(6);
        check("hold_valid", 32'(valid), 1);
        check("ovf_after_first", 32'(overflow), 32'(exp_ovf));
        send_frame(16'h56, 16'h78, 8, 0, 0);
        tick(6);
        check("ovf_after_second", 32'(overflow), 32'(exp_ovf));
        send_frame(16'h9A, 16'hBC, 8, 0, 0);
        tick(6);
        check("hold_data", {16'd0, data_left, data_right}, 32'h1234);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        exp_ovf = 0;
        check("ovf_cleared", 32'(overflow), 32'(exp_ovf));
        ready = 1'b1;
        tick(3);
        hold_mode = 0; model_pending = 0;
        check("valid_after_accept", 32'(valid), 0);

        // Enable dropped mid-left-word, then reset mid-right-word.
        lat_en = 1;
        send_frame(16'h11, 16'h22, 8, 0, 0);
        send_frame(16'h33, 16'h44, 8, 1, 3);
        send_frame(16'h55, 16'h66, 8, 0, 0);
        send_frame(16'h77, 16'h88, 8, 2, 11);
        send_frame(16'h99, 16'hAA, 8, 0, 0);
        tick(10);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_rx_core.md
Name: i2s_rx_core

Overview:
- I2S receiver: the receive-side counterpart of the team's I2S transmitter core.
- Samples an external I2S bus (sck, ws, sd) in the system clock domain. Deserialises MSB-first left/right words and presents each complete stereo pair on a valid/ready interface.
- Sits between the I2S pins and the Avalon slave register/FIFO wrapper of the I2S receive peripheral.

Parameters:
- DW, 8, stored word width per channel.
- SYNC_STAGES, 2, synchroniser flops per bus input (minimum 2).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  receiver enable; low forces resynchronisation.
- sck_in  input  1  I2S serial clock; asynchronous to clk.
- ws_in  input  1  I2S word select: 0 = left, 1 = right.
- sd_in  input  1  I2S serial data, MSB first.
- data_left  output  DW  left word of the presented pair.
- data_right  output  DW  right word of the presented pair.
- valid  output  1  pair available.
- ready  input  1  consumer accepts the pair.
- overflow  output  1  sticky: a pair was dropped.
- clear_ovf  input  1  clears overflow.

Behaviour:
- Reset (clk edge with reset=1): data_left=0, data_right=0, valid=0, overflow=0, state=SYNC, bit counter=0, partial words=0, left_done=0.
- Input capture: sck_in, ws_in and sd_in each pass through SYNC_STAGES flops, so all three share the same delay. One further flop holds the previous synchronised sck.
- sck rise event: synchronised sck=1 and previous=0. Only on this event are ws_s (synchronised ws) and sd_s (synchronised sd) consumed. ws_prev is ws_s as sampled at the previous rise event.
- Bus timing requirement: sck high and low each ≥2 clk periods. Faster buses are outside scope and behaviour is undefined.
- I2S framing, one-bit delay: the rise event on which ws_s first differs from ws_prev carries the LSB (final bit) of the channel selected by ws_prev. The next rise carries the MSB of the new channel.
- Bit placement: bit counter idx counts bits of the current word from 0. On each rise, if idx<DW, sd_s is written to position DW-1-idx of the partial word; idx saturates at DW.
  - Bits beyond DW are discarded (truncation).
  - Words shorter than DW leave the unwritten LSBs at 0 (left-justified).
- Word completion (rise with ws_s != ws_prev): the final bit is placed by the same rule. The counter and the new partial word are then cleared.
  - ws_prev=0: left word complete. Latch it into a left holding register and set left_done.
  - ws_prev=1: right word complete. If left_done=1, publish the pair, then clear left_done. If left_done=0, discard the right word.
- Publish: if valid=0 or ready=1 in the same clk cycle, load data_left/data_right and set valid=1 on that clk edge. Otherwise keep the old pair and set overflow=1.
- Valid/ready handshake:
  - valid stays high with stable data until a clk edge where ready=1; valid then clears unless a publish occurs on the same edge.
  - Latency from the sck_in rise carrying the right LSB to valid=1 is SYNC_STAGES+1 clk cycles, +1 for asynchronous sampling.
- overflow: sticky. Cleared by clear_ovf=1 unless a drop occurs on the same edge; the drop wins.
- State machine:
  - SYNC: bits are ignored. On a rise with ws_prev=1 and ws_s=0 (start of a left word), go to RUN with idx=0 and left_done=0.
  - RUN: normal operation as above.
  - enable=0 (any state): next state SYNC, idx=0, partial words and left_done cleared. valid, data and overflow are retained and the handshake still completes.
- Reset mid-word: everything returns to reset values. The next pair is not published until after a full left word following the first ws 1→0 transition.

Test Plan:
- Reset then idle: enable=1, sck toggling, ws held 0 → valid stays 0, all outputs 0.
- DW=8 frames, 8-bit words, L=0xA5 R=0x3C, ready=1 → after the sync frame, valid pulses once per frame with data_left=0xA5, data_right=0x3C, 3–4 clk after the right LSB rise.
- 10-bit words L=0x2B7 R=0x155 → data_left=0xAD, data_right=0x55 (top 8 bits).
- 6-bit words L=0x2D R=0x13 → data_left=0xB4, data_right=0x4C (zero-padded LSBs).
- ready=0 over three frames with distinct values → first pair held, overflow=1 after the second frame. clear_ovf pulse → overflow=0. ready=1 → first pair accepted.
- enable deasserted mid-left-word, and reset mid-right-word (two runs) → the partial frame is never published; the first published pair is the first full frame after the next ws 1→0 transition.
